// File: rtl/cart_bus_arbiter_pkg.sv
// Shared types and constants for the cartridge bus arbiter.
package cart_arb_pkg;

    localparam int CART_AW = 21;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

    // Requester ids; also used as bit positions in the eligible vector
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_PPU = 1'b1;

endpackage

// File: rtl/cart_bus_arbiter_pick.sv
// Combinational winner selection between the CPU and PPU request ports.
module cart_arb_pick
    import cart_arb_pkg::*;
#(
    parameter bit PPU_PRIORITY = 1'b1
) (
    input  logic [1:0] eligible,
    input  logic       last_grant,
    output logic       winner,
    output logic       valid
);

    // Fixed PPU priority or round-robin on contention, based on PPU_PRIORITY
    always_comb begin
        winner = REQ_CPU;
        valid  = 1'b0;
        case (eligible)
            2'b00: begin
                winner = REQ_CPU;
                valid  = 1'b0;
            end
            2'b01: begin
                winner = REQ_CPU;
                valid  = 1'b1;
            end
            2'b10: begin
                winner = REQ_PPU;
                valid  = 1'b1;
            end
            2'b11: begin
                valid = 1'b1;
                if (PPU_PRIORITY) begin
                    winner = REQ_PPU;
                end else if (last_grant == REQ_PPU) begin
                    winner = REQ_CPU;
                end else begin
                    winner = REQ_PPU;
                end
            end
            default: begin
                winner = REQ_CPU;
                valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cart_bus_arbiter.sv
// Serialises CPU and PPU accesses onto the single cartridge memory port.
// One access takes IDLE -> ISSUE -> RESP, with the ack landing in the
// following IDLE cycle, where the other port may already be granted.
module cart_bus_arbiter
    import cart_arb_pkg::*;
#(
    parameter bit PPU_PRIORITY = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cart_ready,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic               cpu_ram_sel,
    input  logic [CART_AW-1:0] cpu_addr,
    input  logic [7:0]         cpu_wdata,
    output logic               cpu_ack,
    output logic [7:0]         cpu_rdata,
    input  logic               ppu_req,
    input  logic               ppu_we,
    input  logic [CART_AW-1:0] ppu_addr,
    input  logic [7:0]         ppu_wdata,
    output logic               ppu_ack,
    output logic [7:0]         ppu_rdata,
    output logic [CART_AW-1:0] mem_address,
    output logic               mem_prg_sel,
    output logic               mem_chr_sel,
    output logic               mem_ram_sel,
    output logic               mem_rden,
    output logic               mem_wren,
    output logic [7:0]         mem_write_data,
    input  logic [7:0]         mem_read_data
);

    arb_state_t         state_r;
    logic               last_grant_r;
    logic               cur_id_r;
    logic               cur_we_r;
    logic [1:0]         eligible_s;
    logic               winner_s;
    logic               win_valid_s;
    logic [CART_AW-1:0] cand_addr_s;
    logic [7:0]         cand_wdata_s;
    logic               cand_we_s;
    logic               cand_ram_s;

    // A port is eligible only outside its own ack cycle and once the image is loaded
    always_comb begin
        eligible_s          = 2'b00;
        eligible_s[REQ_CPU] = cpu_req & ~cpu_ack & cart_ready;
        eligible_s[REQ_PPU] = ppu_req & ~ppu_ack & cart_ready;
    end

    cart_arb_pick #(
        .PPU_PRIORITY(PPU_PRIORITY)
    ) u_pick (
        .eligible   (eligible_s),
        .last_grant (last_grant_r),
        .winner     (winner_s),
        .valid      (win_valid_s)
    );

    // Route the winning port's command fields toward the issue registers
    always_comb begin
        cand_addr_s  = {CART_AW{1'b0}};
        cand_wdata_s = 8'h00;
        cand_we_s    = 1'b0;
        cand_ram_s   = 1'b0;
        if (winner_s == REQ_PPU) begin
            cand_addr_s  = ppu_addr;
            cand_wdata_s = ppu_wdata;
            cand_we_s    = ppu_we;
            cand_ram_s   = 1'b0;
        end else begin
            cand_addr_s  = cpu_addr;
            cand_wdata_s = cpu_wdata;
            cand_we_s    = cpu_we;
            cand_ram_s   = cpu_ram_sel;
        end
    end

    // Arbiter FSM; memory command, acks and read data are all registered here
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ARB_IDLE;
            last_grant_r   <= REQ_PPU;
            cur_id_r       <= REQ_CPU;
            cur_we_r       <= 1'b0;
            cpu_ack        <= 1'b0;
            ppu_ack        <= 1'b0;
            cpu_rdata      <= 8'h00;
            ppu_rdata      <= 8'h00;
            mem_address    <= {CART_AW{1'b0}};
            mem_prg_sel    <= 1'b0;
            mem_chr_sel    <= 1'b0;
            mem_ram_sel    <= 1'b0;
            mem_rden       <= 1'b0;
            mem_wren       <= 1'b0;
            mem_write_data <= 8'h00;
        end else begin
            cpu_ack <= 1'b0;
            ppu_ack <= 1'b0;
            case (state_r)
                ARB_IDLE: begin
                    if (win_valid_s) begin
                        state_r        <= ARB_ISSUE;
                        last_grant_r   <= winner_s;
                        cur_id_r       <= winner_s;
                        cur_we_r       <= cand_we_s;
                        mem_address    <= cand_addr_s;
                        mem_rden       <= ~cand_we_s;
                        mem_wren       <= cand_we_s;
                        mem_write_data <= cand_we_s ? cand_wdata_s : 8'h00;
                        mem_chr_sel    <= (winner_s == REQ_PPU);
                        mem_prg_sel    <= (winner_s == REQ_CPU) & ~cand_ram_s;
                        mem_ram_sel    <= (winner_s == REQ_CPU) & cand_ram_s;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_ISSUE: begin
                    state_r        <= ARB_RESP;
                    mem_address    <= {CART_AW{1'b0}};
                    mem_prg_sel    <= 1'b0;
                    mem_chr_sel    <= 1'b0;
                    mem_ram_sel    <= 1'b0;
                    mem_rden       <= 1'b0;
                    mem_wren       <= 1'b0;
                    mem_write_data <= 8'h00;
                end
                ARB_RESP: begin
                    state_r <= ARB_IDLE;
                    if (cur_id_r == REQ_PPU) begin
                        ppu_ack <= 1'b1;
                        if (!cur_we_r) begin
                            ppu_rdata <= mem_read_data;
                        end else begin
                            ppu_rdata <= ppu_rdata;
                        end
                    end else begin
                        cpu_ack <= 1'b1;
                        if (!cur_we_r) begin
                            cpu_rdata <= mem_read_data;
                        end else begin
                            cpu_rdata <= cpu_rdata;
                        end
                    end
                end
                default: begin
                    state_r        <= ARB_IDLE;
                    mem_address    <= {CART_AW{1'b0}};
                    mem_prg_sel    <= 1'b0;
                    mem_chr_sel    <= 1'b0;
                    mem_ram_sel    <= 1'b0;
                    mem_rden       <= 1'b0;
                    mem_wren       <= 1'b0;
                    mem_write_data <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Directed bench: one arbiter with PPU priority (p_*) and one round-robin (r_*),
// both driven by the same request ports.
module tb_cart_bus_arbiter;

    logic        clock;
    logic        reset;
    logic        cart_ready;
    logic        cpu_req, cpu_we, cpu_ram_sel;
    logic [20:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        ppu_req, ppu_we;
    logic [20:0] ppu_addr;
    logic [7:0]  ppu_wdata;
    logic [7:0]  rd_val;

    logic        p_cpu_ack, p_ppu_ack, r_cpu_ack, r_ppu_ack;
    logic [7:0]  p_cpu_rdata, p_ppu_rdata, r_cpu_rdata, r_ppu_rdata;
    logic [20:0] p_mem_address, r_mem_address;
    logic        p_mem_prg_sel, p_mem_chr_sel, p_mem_ram_sel, p_mem_rden, p_mem_wren;
    logic        r_mem_prg_sel, r_mem_chr_sel, r_mem_ram_sel, r_mem_rden, r_mem_wren;
    logic [7:0]  p_mem_write_data, r_mem_write_data;
    logic [7:0]  p_mem_read_data, r_mem_read_data;

    int total = 0;
    int bad   = 0;
    logic act;

    cart_bus_arbiter #(.PPU_PRIORITY(1'b1)) dut_p (
        .clock(clock), .reset(reset), .cart_ready(cart_ready),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ram_sel(cpu_ram_sel),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(p_cpu_ack), .cpu_rdata(p_cpu_rdata),
        .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata),
        .ppu_ack(p_ppu_ack), .ppu_rdata(p_ppu_rdata),
        .mem_address(p_mem_address), .mem_prg_sel(p_mem_prg_sel),
        .mem_chr_sel(p_mem_chr_sel), .mem_ram_sel(p_mem_ram_sel),
        .mem_rden(p_mem_rden), .mem_wren(p_mem_wren),
        .mem_write_data(p_mem_write_data), .mem_read_data(p_mem_read_data)
    );

    cart_bus_arbiter #(.PPU_PRIORITY(1'b0)) dut_r (
        .clock(clock), .reset(reset), .cart_ready(cart_ready),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ram_sel(cpu_ram_sel),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(r_cpu_ack), .cpu_rdata(r_cpu_rdata),
        .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata),
        .ppu_ack(r_ppu_ack), .ppu_rdata(r_ppu_rdata),
        .mem_address(r_mem_address), .mem_prg_sel(r_mem_prg_sel),
        .mem_chr_sel(r_mem_chr_sel), .mem_ram_sel(r_mem_ram_sel),
        .mem_rden(r_mem_rden), .mem_wren(r_mem_wren),
        .mem_write_data(r_mem_write_data), .mem_read_data(r_mem_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory models: data valid the cycle after a read command
    always @(posedge clock) begin
        p_mem_read_data <= p_mem_rden ? rd_val : 8'h00;
        r_mem_read_data <= r_mem_rden ? rd_val : 8'h00;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; cart_ready = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_ram_sel = 1'b0; cpu_addr = 21'h0; cpu_wdata = 8'h00;
        ppu_req = 1'b0; ppu_we = 1'b0; ppu_addr = 21'h0; ppu_wdata = 8'h00;
        rd_val = 8'h00;
        tick(); tick();
        chk("rst_cpu_ack", {p_cpu_ack, r_cpu_ack}, 2'b00);
        chk("rst_ppu_ack", {p_ppu_ack, r_ppu_ack}, 2'b00);
        chk("rst_rdata", {p_cpu_rdata, p_ppu_rdata, r_cpu_rdata}, 24'h0);
        chk("rst_mem", {p_mem_rden, p_mem_wren, p_mem_prg_sel, p_mem_chr_sel, r_mem_rden}, 5'b0);
        reset = 1'b0;
        tick();

        // CPU PRG read at 0x00123
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_ram_sel = 1'b0; cpu_addr = 21'h00123; rd_val = 8'h5A;
        tick();
        chk("t1_issue_ctl", {p_mem_rden, p_mem_wren, p_mem_prg_sel, p_mem_chr_sel, p_mem_ram_sel}, 5'b10100);
        chk("t1_issue_addr", p_mem_address, 21'h00123);
        chk("t1_issue_r", r_mem_rden, 1'b1);
        tick();
        chk("t1_resp_idle", {p_mem_rden, p_cpu_ack, p_mem_prg_sel}, 3'b000);
        chk("t1_resp_addr0", p_mem_address, 21'h0);
        tick();
        chk("t1_ack", {p_cpu_ack, r_cpu_ack, p_ppu_ack}, 3'b110);
        chk("t1_rdata", {p_cpu_rdata, r_cpu_rdata}, 16'h5A5A);
        cpu_req = 1'b0;
        tick();
        chk("t1_after", {p_cpu_ack, p_mem_rden}, 2'b00);

        // PPU read, then PPU write to CHR 0x01FFF leaving ppu_rdata alone
        ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 21'h00010; rd_val = 8'h3C;
        tick(); tick(); tick();
        chk("t2_rd_ack", {p_ppu_ack, p_ppu_rdata}, 9'h13C);
        ppu_we = 1'b1; ppu_addr = 21'h01FFF; ppu_wdata = 8'hC3; rd_val = 8'hEE;
        tick();
        chk("t2_no_reissue_in_ack", {p_mem_rden, p_mem_wren, r_mem_wren}, 3'b000);
        tick();
        chk("t2_wr_ctl", {p_mem_wren, p_mem_rden, p_mem_chr_sel, p_mem_prg_sel, p_mem_ram_sel}, 5'b10100);
        chk("t2_wr_data", {p_mem_address, p_mem_write_data}, {21'h01FFF, 8'hC3});
        tick(); tick();
        chk("t2_wr_ack", {p_ppu_ack, r_ppu_ack}, 2'b11);
        chk("t2_rdata_kept", {p_ppu_rdata, r_ppu_rdata}, 16'h3C3C);
        ppu_req = 1'b0;
        tick();

        // Both ports requesting continuously
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h00100;
        ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 21'h00200; rd_val = 8'h11;
        tick();
        chk("t3_g1_r_cpu", {r_mem_prg_sel, r_mem_chr_sel}, 2'b10);
        chk("t3_g1_p_ppu", {p_mem_prg_sel, p_mem_chr_sel}, 2'b01);
        tick(); tick();
        chk("t3_a1_r", {r_cpu_ack, r_ppu_ack, r_cpu_rdata}, 10'h211);
        chk("t3_a1_p", {p_cpu_ack, p_ppu_ack}, 2'b01);
        tick();
        chk("t3_g2_r_ppu", {r_mem_prg_sel, r_mem_chr_sel}, 2'b01);
        chk("t3_g2_p_cpu", {p_mem_prg_sel, p_mem_chr_sel}, 2'b10);
        tick(); tick();
        chk("t3_a2", {r_cpu_ack, r_ppu_ack, p_cpu_ack, p_ppu_ack}, 4'b0110);
        tick();
        chk("t3_g3", {r_mem_prg_sel, r_mem_chr_sel, p_mem_prg_sel, p_mem_chr_sel}, 4'b1001);
        tick(); tick();
        chk("t3_a3", {r_cpu_ack, r_ppu_ack, p_cpu_ack, p_ppu_ack}, 4'b1001);
        cpu_req = 1'b0; ppu_req = 1'b0;
        tick();

        // No grants while the image is not loaded
        cart_ready = 1'b0; cpu_req = 1'b1; ppu_req = 1'b1; rd_val = 8'h22;
        act = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            act = act | p_mem_rden | p_mem_wren | r_mem_rden | r_mem_wren
                      | p_cpu_ack | p_ppu_ack | r_cpu_ack | r_ppu_ack;
        end
        chk("t4_quiet_not_ready", act, 1'b0);
        cart_ready = 1'b1;
        tick();
        chk("t4_first_cmd", {p_mem_chr_sel, r_mem_chr_sel, r_mem_prg_sel, p_mem_rden}, 4'b1101);
        tick(); tick();
        chk("t4_ppu_ack", {p_ppu_ack, r_ppu_ack}, 2'b11);
        ppu_req = 1'b0;
        tick();
        chk("t4_cpu_cmd", {p_mem_prg_sel, r_mem_prg_sel}, 2'b11);
        cart_ready = 1'b0;
        tick(); tick();
        chk("t4_completes", {p_cpu_ack, r_cpu_ack, p_cpu_rdata, r_cpu_rdata}, {2'b11, 16'h2222});
        cpu_req = 1'b0; cart_ready = 1'b1;
        tick();

        // Reset during ISSUE, then re-serve the held request
        cpu_req = 1'b1; cpu_addr = 21'h00456; rd_val = 8'h77;
        tick();
        chk("t5_issue", {p_mem_rden, r_mem_rden}, 2'b11);
        reset = 1'b1;
        tick();
        chk("t5_rst_mem", {p_mem_rden, p_mem_prg_sel, r_mem_rden, r_mem_prg_sel}, 4'b0);
        chk("t5_rst_addr", {p_mem_address, r_mem_address}, 42'h0);
        chk("t5_rst_rdata", {p_cpu_rdata, p_ppu_rdata, r_cpu_rdata, r_ppu_rdata}, 32'h0);
        reset = 1'b0;
        ppu_req = 1'b1; ppu_we = 1'b0; ppu_addr = 21'h00300;
        tick();
        chk("t5_r_cpu_after_rst", {r_mem_prg_sel, r_mem_chr_sel, r_cpu_ack}, 3'b100);
        chk("t5_r_addr", r_mem_address, 21'h00456);
        chk("t5_p_ppu", p_mem_chr_sel, 1'b1);
        ppu_req = 1'b0;
        tick(); tick();
        chk("t5_acks", {r_cpu_ack, r_cpu_rdata, p_ppu_ack, p_ppu_rdata}, {1'b1, 8'h77, 1'b1, 8'h77});
        tick();
        chk("t5_held_no_reissue", {r_mem_rden, r_cpu_ack}, 2'b00);
        chk("t5_p_cpu_cmd", p_mem_prg_sel, 1'b1);
        tick();
        chk("t5_held_second", {r_mem_rden, r_mem_prg_sel}, 2'b11);
        cpu_req = 1'b0;
        tick();
        chk("t5_p_cpu_ack", p_cpu_ack, 1'b1);
        tick();
        chk("t5_r_second_ack", r_cpu_ack, 1'b1);
        tick();
        chk("t5_final_idle", {r_mem_rden, r_cpu_ack, p_mem_rden, p_cpu_ack}, 4'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
